// File: rtl/unsigned_mul_8x8_ha_accum_pkg.sv
// mul8_ha_pkg: shared widths and FSM state type for the serial half-adder row accumulator
package mul8_ha_pkg;
  localparam int NUM_PAIRS = 4;
  localparam int T_W = 9;
  localparam int B_W = 7;
  localparam int PAIR_W = 10;
  localparam int ACC_W = 17;
  localparam int PROD_W = 16;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;
endpackage

// File: rtl/unsigned_mul_8x8_ha_accum_if.sv
// unsigned_mul_8x8_ha_accum_if: row-pair input handshake (in_valid/in_ready, ha_array_k_t/b) and result handshake (out_valid/out_ready, product, sat)
interface unsigned_mul_8x8_ha_accum_if;
  import mul8_ha_pkg::*;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;
  logic sat;
  logic [PROD_W-1:0] product;
  logic [T_W-1:0] ha_array_0_t, ha_array_1_t, ha_array_2_t, ha_array_3_t;
  logic [B_W-1:0] ha_array_0_b, ha_array_1_b, ha_array_2_b, ha_array_3_b;
  modport master (
    output in_valid, out_ready,
    output ha_array_0_t, ha_array_1_t, ha_array_2_t, ha_array_3_t,
    output ha_array_0_b, ha_array_1_b, ha_array_2_b, ha_array_3_b,
    input in_ready, out_valid, product, sat
  );
  modport slave (
    input in_valid, out_ready,
    input ha_array_0_t, ha_array_1_t, ha_array_2_t, ha_array_3_t,
    input ha_array_0_b, ha_array_1_b, ha_array_2_b, ha_array_3_b,
    output in_ready, out_valid, product, sat
  );
endinterface

// File: rtl/unsigned_mul_8x8_ha_accum_pair_eval.sv
// mul8_ha_pair_eval: value of one row pair, t_i (9b, weight 2^i) + b_i (7b, weight 2^(i+2)) -> p_o (10b)
module mul8_ha_pair_eval
  import mul8_ha_pkg::*;
(
  input  logic [T_W-1:0]    t_i,
  input  logic [B_W-1:0]    b_i,
  output logic [PAIR_W-1:0] p_o
);
  assign p_o = PAIR_W'(t_i) + PAIR_W'({b_i, 2'b00});
endmodule

// File: rtl/unsigned_mul_8x8_ha_accum.sv
// unsigned_mul_8x8_ha_accum: serial weighted sum of four HA row pairs, saturated to 16 bits; ports clk, rst_n (async active-low), bus (slave modport)
module unsigned_mul_8x8_ha_accum
  import mul8_ha_pkg::*;
#(
  parameter int NUM_PAIRS = mul8_ha_pkg::NUM_PAIRS,
  parameter int ACC_W = mul8_ha_pkg::ACC_W
) (
  input logic clk,
  input logic rst_n,
  unsigned_mul_8x8_ha_accum_if.slave bus
);
  localparam int CNT_W = $clog2(NUM_PAIRS);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [ACC_W-1:0] acc_q, acc_d, term;
  logic [T_W-1:0] t_q [NUM_PAIRS];
  logic [T_W-1:0] t_in [NUM_PAIRS];
  logic [B_W-1:0] b_q [NUM_PAIRS];
  logic [B_W-1:0] b_in [NUM_PAIRS];
  logic [PAIR_W-1:0] pair;
  logic [PROD_W-1:0] product_q, product_d;
  logic sat_q, sat_d, in_ready_w, in_fire, last;
  assign t_in[0] = bus.ha_array_0_t;
  assign t_in[1] = bus.ha_array_1_t;
  assign t_in[2] = bus.ha_array_2_t;
  assign t_in[3] = bus.ha_array_3_t;
  assign b_in[0] = bus.ha_array_0_b;
  assign b_in[1] = bus.ha_array_1_b;
  assign b_in[2] = bus.ha_array_2_b;
  assign b_in[3] = bus.ha_array_3_b;
  mul8_ha_pair_eval u_eval (
    .t_i(t_q[cnt_q]),
    .b_i(b_q[cnt_q]),
    .p_o(pair)
  );
  always_comb begin
    in_ready_w = state_q == IDLE || (state_q == DONE && bus.out_ready);
    in_fire = bus.in_valid && in_ready_w;
    last = cnt_q == CNT_W'(NUM_PAIRS - 1);
    term = ACC_W'(pair) << {cnt_q, 1'b0};
    acc_d = acc_q + term;
    sat_d = |acc_d[ACC_W-1:PROD_W];
    product_d = sat_d ? '1 : acc_d[PROD_W-1:0];
    state_d = in_fire ? ACCUM
            : (state_q == ACCUM && last) ? DONE
            : (state_q == DONE && bus.out_ready) ? IDLE
            : state_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      product_q <= '0;
      sat_q <= 1'b0;
      t_q <= '{default: '0};
      b_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      if (in_fire) begin
        t_q <= t_in;
        b_q <= b_in;
        cnt_q <= '0;
        acc_q <= '0;
      end else if (state_q == ACCUM) begin
        cnt_q <= cnt_q + CNT_W'(1);
        acc_q <= acc_d;
        if (last) begin
          product_q <= product_d;
          sat_q <= sat_d;
        end
      end
    end
  assign bus.in_ready = in_ready_w;
  assign bus.out_valid = state_q == DONE;
  assign bus.product = product_q;
  assign bus.sat = sat_q;
endmodule

// File: doc/unsigned_mul_8x8_ha_accum.md
# unsigned_mul_8x8_ha_accum

Sequential final-summation stage for the approximate 8x8 unsigned multipliers. It sits directly downstream of the `ha_array` first-stage generators. It captures the four half-adder row pairs (`ha_array_k_b`, `ha_array_k_t`, k = 0..3), accumulates one pair per cycle with the correct binary weights, and returns a saturated 16-bit product over a valid/ready handshake. This is the area-lean serial alternative to a full compressor tree.

## Interface
Parameters:
- `NUM_PAIRS`, 4: number of row pairs accepted. Fixed at 4 for 8x8.
- `ACC_W`, 17: accumulator width. Must be at least 17 so the worst-case sum never wraps.

Ports:
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: a row-pair set is presented.
- `in_ready` output 1: the block can accept a set this cycle.
- `ha_array_k_t` input 9 (k = 0..3): top row of pair k.
- `ha_array_k_b` input 7 (k = 0..3): bottom row of pair k.
- `out_valid` output 1: `product` and `sat` are valid.
- `out_ready` input 1: the consumer accepts the result.
- `product` output 16: saturated sum.
- `sat` output 1: the true sum exceeded 0xFFFF.

## Operation
- Pair value: P_k = Σ_i t[i]·2^i (i = 0..8) + Σ_i b[i]·2^(i+2) (i = 0..6). P_k is at most 1019, which fits in 10 bits.
- Weighted contribution: P_k << 2k.
- Total sum: Σ P_k·4^k. The maximum is 1019·85 = 86615, so the 17-bit accumulator never wraps.
- States:
  - IDLE: `in_ready`=1, `out_valid`=0.
  - ACCUM: `in_ready`=0, `out_valid`=0.
  - DONE: `out_valid`=1.
- IDLE, on `in_valid`&`in_ready`:
  - Register all 64 row bits.
  - Clear `acc` and `cnt`.
  - Go to ACCUM.
- ACCUM, each cycle:
  - acc ← acc + (P_cnt << 2·cnt).
  - cnt ← cnt + 1.
  - When cnt == 3, perform the add, then go to DONE.
- DONE:
  - `product` = 0xFFFF if acc > 0xFFFF, otherwise acc[15:0]. `sat` = (acc > 0xFFFF).
  - Both outputs are registered and held stable while `out_valid`=1 and `out_ready`=0.
- DONE, on `out_ready`=1:
  - If `in_valid` is also high, accept the new set and go straight to ACCUM (`in_ready` = DONE & `out_ready`).
  - Otherwise go to IDLE.
- `in_ready` is combinational from state and `out_ready`. There is no combinational path from `in_valid` to `in_ready`.
- Input rows are sampled only on the accept edge. Changes to the inputs during ACCUM are ignored.

## Timing
- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, `product`=0, `sat`=0, acc=0, cnt=0.
- Reset asserted mid-ACCUM or mid-DONE: the in-flight result is discarded with no output. After deassertion the block is in IDLE on the first edge.
- Latency: accept at edge E0. Adds happen on E1..E4. `out_valid` is high after E4, i.e. 4 cycles from accept to valid.
- Throughput: with `out_ready` held high, one result every 5 cycles (4 ACCUM cycles plus 1 DONE cycle that overlaps the next accept).
- A result is transferred on `out_valid`&`out_ready`. A set is consumed on `in_valid`&`in_ready`.

## Structure
- Package `mul8_ha_pkg` holds:
  - `NUM_PAIRS`, `T_W`=9, `B_W`=7, `PAIR_W`=10, `ACC_W`=17, `PROD_W`=16.
  - State enum {IDLE, ACCUM, DONE}.
- Sub-module `mul8_ha_pair_eval`: combinational; 9-bit t and 7-bit b in, 10-bit P_k out. One instance, fed by a 4:1 mux on cnt.

## Test plan
- Only `ha_array_0_t`=9'h001 set, others 0, `out_ready`=1 → `out_valid` 4 cycles after accept, `product`=0x0001, `sat`=0.
- Only `ha_array_1_t`=9'h100 set → `product`=0x0400. Separately, only `ha_array_3_b`=7'h40 set → `product`=0x4000.
- All 64 row bits = 1 → acc=86615, `product`=0xFFFF, `sat`=1.
- Hold `out_ready`=0 for 3 cycles in DONE → `product` and `sat` stable, `in_ready`=0; the transfer happens on the cycle `out_ready` rises.
- Back-to-back: `in_valid` and `out_ready` held high, alternating the 0x0001 and 0x4000 sets → one result every 5 cycles, in order.
- Assert `rst_n`=0 at the second ACCUM cycle → `out_valid` stays 0, and the next accepted set produces only its own sum.
